// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot engine: opcodes, FSM states, command word layout.
package vga_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam int CMD_W   = 32;
    localparam int Y_MSB   = 30;
    localparam int Y_LSB   = 24;
    localparam int X_MSB   = 23;
    localparam int X_LSB   = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int LEN_MSB = 13;
    localparam int LEN_LSB = 8;
    localparam int COL_MSB = 7;
    localparam int COL_LSB = 0;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_HLINE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PIXEL = 2'b01,
        ST_HLINE = 2'b10,
        ST_FILL  = 2'b11
    } state_e;

    typedef struct packed {
        logic       spare;
        logic [6:0] y;
        logic [7:0] x;
        opcode_e    op;
        logic [5:0] len;
        logic [7:0] colour;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] word);
        cmd_t c;
        c.spare  = word[CMD_W-1];
        c.y      = word[Y_MSB:Y_LSB];
        c.x      = word[X_MSB:X_LSB];
        c.op     = opcode_e'(word[OP_MSB:OP_LSB]);
        c.len    = word[LEN_MSB:LEN_LSB];
        c.colour = word[COL_MSB:COL_LSB];
        return c;
    endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Command queue: synchronous FIFO with count-based full/empty and the head word always presented.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module vga_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/vga_plot_engine.sv
// Command-driven pixel plotter: queues 32-bit commands and emits one registered pixel write per clock.
// Latency: first vga_plot appears two edges after a command is accepted into an idle engine.
// Backpressure: ready drops while the command queue is full; start without ready is ignored.
module vga_plot_engine
    import vga_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int COLOUR_W   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         data_in,
    output logic                ready,
    output logic                busy,
    output logic                err,
    output logic                vga_plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour
);

    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_e              state;
    logic [8:0]          cur_x;
    logic [6:0]          cur_y;
    logic [8:0]          step_cnt;
    logic [COLOUR_W-1:0] cur_col;

    logic             push;
    logic             load;
    logic             last_step;
    logic             in_bounds;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head_word;
    cmd_t             head;
    logic             unused_cmd_bits;

    assign ready = !rst && !fifo_full;
    assign push  = start && ready;
    assign busy  = (state != ST_IDLE) || !fifo_empty;
    assign head  = decode_cmd(head_word);
    assign unused_cmd_bits = ^{head.spare, head.colour};

    vga_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (data_in),
        .pop      (load),
        .head_dat (head_word),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        last_step = 1'b0;
        case (state)
            ST_PIXEL: last_step = 1'b1;
            // A line stops at the right screen edge rather than wrapping.
            ST_HLINE: last_step = (step_cnt == 9'd0) || (cur_x == X_LAST);
            ST_FILL:  last_step = (cur_x == X_LAST) && (cur_y == Y_LAST);
            default:  last_step = 1'b0;
        endcase
    end

    // Popping on the final step keeps consecutive commands gap-free.
    assign load      = ((state == ST_IDLE) || last_step) && !fifo_empty;
    assign in_bounds = (cur_x < X_LIM) && ({1'b0, cur_y} < Y_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            step_cnt   <= '0;
            cur_col    <= '0;
            err        <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            if (state != ST_IDLE) begin
                vga_plot   <= in_bounds;
                vga_x      <= cur_x[7:0];
                vga_y      <= cur_y;
                vga_colour <= cur_col;
            end else begin
                vga_plot <= 1'b0;
            end

            if (load) begin
                case (head.op)
                    OP_PIXEL: begin
                        state    <= ST_PIXEL;
                        cur_x    <= {1'b0, head.x};
                        cur_y    <= head.y;
                        step_cnt <= '0;
                        cur_col  <= head.colour[COLOUR_W-1:0];
                    end
                    OP_HLINE: begin
                        state    <= ST_HLINE;
                        cur_x    <= {1'b0, head.x};
                        cur_y    <= head.y;
                        step_cnt <= {3'b000, head.len};
                        cur_col  <= head.colour[COLOUR_W-1:0];
                    end
                    OP_FILL: begin
                        state    <= ST_FILL;
                        cur_x    <= '0;
                        cur_y    <= '0;
                        step_cnt <= '0;
                        cur_col  <= head.colour[COLOUR_W-1:0];
                    end
                    default: begin
                        state <= ST_IDLE;
                        err   <= 1'b1;
                    end
                endcase
            end else if (last_step) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_HLINE: begin
                        cur_x    <= cur_x + 9'd1;
                        step_cnt <= step_cnt - 9'd1;
                    end
                    ST_FILL: begin
                        if (cur_x == X_LAST) begin
                            cur_x <= '0;
                            cur_y <= cur_y + 7'd1;
                        end else begin
                            cur_x <= cur_x + 9'd1;
                        end
                    end
                    default: begin
                        cur_x <= cur_x;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_engine.sv
// Self-checking bench for vga_plot_engine: command table plus hand-built latency, backpressure, fill and reset sequences.
module tb_vga_plot_engine;

    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic        ready;
    logic        busy;
    logic        err;
    logic        vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    always #5 clk = ~clk;

    vga_plot_engine #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .COLOUR_W   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ready      (ready),
        .busy       (busy),
        .err        (err),
        .vga_plot   (vga_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        string       name;
        logic [31:0] word;
        int          plots;
        int          vx;
        int          vy;
    } vec_t;

    pix_t        exp_q[$];
    vec_t        vecs[8];
    logic [31:0] pw[6];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          plot_total = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic [7:0]  last_x = '0;
    logic [6:0]  last_y = '0;
    bit          mon_en = 1'b1;
    int          p0;
    int          acc;
    int          acc_at_low;
    bit          low_seen;
    bit          r;

    function automatic logic [31:0] mk(input int y, input int x, input int op, input int len, input int col);
        return {1'b0, 7'(y), 8'(x), 2'(op), 6'(len), 8'(col)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock, sampled on the falling edge; every plot is matched against the scoreboard.
    task automatic tick();
        pix_t got;
        pix_t want;
        @(negedge clk);
        cyc++;
        if (vga_plot) begin
            got = {vga_x, vga_y, vga_colour};
            plot_total++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            last_x = vga_x;
            last_y = vga_y;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=(%0d,%0d,%0d) required=no plot", vga_x, vga_y, vga_colour);
                end else begin
                    want = exp_q.pop_front();
                    check("sb_pixel", 32'(got), 32'(want));
                end
            end
        end
    endtask

    // Reference behaviour of one command, pushed in plot order.
    task automatic model(input logic [31:0] w);
        int x;
        int y;
        int op;
        int len;
        logic [2:0] c;
        y = int'(w[30:24]);
        x = int'(w[23:16]);
        op = int'(w[15:14]);
        len = int'(w[13:8]);
        c = w[2:0];
        case (op)
            0: if (x < W && y < H) exp_q.push_back({8'(x), 7'(y), c});
            1: for (int xx = x; xx <= x + len; xx++) begin
                   if (xx < W && y < H) exp_q.push_back({8'(xx), 7'(y), c});
                   if (xx == W - 1) break;
               end
            2: for (int yy = 0; yy < H; yy++)
                   for (int xx = 0; xx < W; xx++)
                       exp_q.push_back({8'(xx), 7'(yy), c});
            default: ;
        endcase
    endtask

    task automatic send_cmd(input logic [31:0] w);
        bit done = 1'b0;
        start = 1'b1;
        data_in = w;
        for (int i = 0; i < 40000 && !done; i++) begin
            done = ready;
            tick();
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not accepted required=accepted word=%08h", w);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check({name, "_idle"}, 32'(busy), 32'd0);
        tick();
        check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;

        vecs[0] = '{"hline_clip_157",  mk(0, 157, 1, 9, 5),        3, 159, 0};
        vecs[1] = '{"pix_x200",        mk(119, 200, 0, 0, 2),      0, 200, 119};
        vecs[2] = '{"pix_y120",        mk(120, 159, 0, 0, 2),      0, 159, 120};
        vecs[3] = '{"hline_row119",    mk(119, 0, 1, 3, 2),        4, 3, 119};
        vecs[4] = '{"hline_offscreen", mk(20, 240, 1, 10, 6),      0, 250, 20};
        vecs[5] = '{"pix_spare_bits",  mk(0, 0, 0, 0, 8'hFD) | 32'h8000_0000, 1, 0, 0};
        vecs[6] = '{"hline_len0",      mk(60, 159, 1, 0, 1),       1, 159, 60};
        vecs[7] = '{"hline_edge_stop", mk(3, 100, 1, 63, 4),       60, 159, 3};

        repeat (3) tick();
        check("rst_ready_low", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_plot", 32'(vga_plot), 32'd0);
        check("post_rst_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single pixel: plot must appear exactly two edges after acceptance.
        model(mk(5, 10, 0, 0, 3));
        p0 = plot_total;
        send_cmd(mk(5, 10, 0, 0, 3));
        check("lat_edge_n", 32'(vga_plot), 32'd0);
        tick();
        check("lat_edge_n1", 32'(vga_plot), 32'd0);
        tick();
        check("lat_edge_n2", 32'(vga_plot), 32'd1);
        check("lat_xyc", 32'({vga_x, vga_y, vga_colour}), 32'({8'd10, 7'd5, 3'd3}));
        tick();
        check("lat_single_pulse", 32'(vga_plot), 32'd0);
        wait_idle("pix", 50);
        check("pix_plots", 32'(plot_total - p0), 32'd1);

        foreach (vecs[i]) begin
            p0 = plot_total;
            model(vecs[i].word);
            send_cmd(vecs[i].word);
            wait_idle(vecs[i].name, 200);
            check({vecs[i].name, "_plots"}, 32'(plot_total - p0), 32'(vecs[i].plots));
            check({vecs[i].name, "_vga_x"}, 32'(vga_x), 32'(vecs[i].vx));
            check({vecs[i].name, "_vga_y"}, 32'(vga_y), 32'(vecs[i].vy));
            check({vecs[i].name, "_err"}, 32'(err), 32'd0);
        end

        // Backpressure: six pixels held on start while a fill occupies the engine.
        for (int k = 0; k < 6; k++) pw[k] = mk(k + 1, 10 * k + 3, 0, 0, k);
        model(mk(0, 0, 2, 0, 1));
        for (int k = 0; k < 6; k++) model(pw[k]);
        p0 = plot_total;
        first_cyc = -1;
        send_cmd(mk(0, 0, 2, 0, 1));
        acc = 0;
        acc_at_low = -1;
        low_seen = 1'b0;
        for (int i = 0; i < 30000 && acc < 6; i++) begin
            start = 1'b1;
            data_in = pw[acc];
            r = ready;
            if (!r && !low_seen) begin
                low_seen = 1'b1;
                acc_at_low = acc;
            end
            tick();
            if (r) acc++;
        end
        start = 1'b0;
        check("bp_accepts_before_full", 32'(acc_at_low), 32'd4);
        check("bp_all_accepted", 32'(acc), 32'd6);
        wait_idle("bp", 30000);
        check("bp_plots", 32'(plot_total - p0), 32'(W * H + 6));
        check("bp_one_per_clk", 32'(last_cyc - first_cyc + 1), 32'(W * H + 6));

        // Full-screen fill in colour 7.
        model(mk(0, 0, 2, 0, 7));
        p0 = plot_total;
        first_cyc = -1;
        send_cmd(mk(0, 0, 2, 0, 7));
        wait_idle("fill", 20000);
        check("fill_plots", 32'(plot_total - p0), 32'(W * H));
        check("fill_consecutive", 32'(last_cyc - first_cyc + 1), 32'(W * H));
        check("fill_last_xy", 32'({last_x, last_y}), 32'({8'd159, 7'd119}));
        check("fill_end_plot", 32'(vga_plot), 32'd0);
        check("fill_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a long line, with a start coincident with reset.
        mon_en = 1'b0;
        send_cmd(mk(10, 0, 1, 63, 4));
        send_cmd(mk(11, 5, 0, 0, 2));
        repeat (4) tick();
        check("mid_hline_plotting", 32'(vga_plot), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        data_in = mk(1, 1, 0, 0, 1);
        p0 = plot_total;
        tick();
        check("rst_mid_plot", 32'(vga_plot), 32'd0);
        check("rst_mid_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("rst_mid_ready_after", 32'(ready), 32'd1);
        check("rst_start_dropped", 32'(busy), 32'd0);
        repeat (5) tick();
        check("rst_mid_no_plots", 32'(plot_total - p0), 32'd0);
        exp_q.delete();
        mon_en = 1'b1;

        // Reserved opcode: sticky error, no plot, cleared only by reset.
        p0 = plot_total;
        send_cmd(mk(2, 2, 3, 0, 1));
        wait_idle("rsvd", 50);
        check("rsvd_err", 32'(err), 32'd1);
        check("rsvd_no_plot", 32'(plot_total - p0), 32'd0);
        model(mk(7, 7, 0, 0, 4));
        send_cmd(mk(7, 7, 0, 0, 4));
        wait_idle("after_rsvd", 50);
        check("rsvd_err_sticky", 32'(err), 32'd1);
        check("after_rsvd_plots", 32'(plot_total - p0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rsvd_err_cleared", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_engine.md
VGA_PLOT_ENGINE -- requirements
Module: vga_plot_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning visible pixels per row.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning visible rows.
REQ-003 SHALL have parameter COLOUR_W, default 3, meaning colour bits per pixel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, meaning command queue entries.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, command valid.
REQ-008 SHALL have port data_in, input, 32, command word.
REQ-009 SHALL have port ready, output, 1, command queue can accept.
REQ-010 SHALL have port busy, output, 1, engine or queue non-idle.
REQ-011 SHALL have port err, output, 1, sticky reserved-opcode flag.
REQ-012 SHALL have ports vga_plot (output, 1), vga_x (output, 8), vga_y (output, 7) and vga_colour (output, COLOUR_W), the pixel write strobe and coordinates.

Function
REQ-013 SHALL decode the command word as: y = [30:24], x = [23:16], opcode = [15:14], len = [13:8], colour = [COLOUR_W-1:0]; bit 31 ignored.
REQ-014 SHALL encode opcodes as: 00 PIXEL; 01 HLINE of len+1 pixels from (x,y) rightwards; 10 FILL the whole screen with colour; 11 reserved.
REQ-015 SHALL accept a command on a rising edge where start && ready; start while !ready is ignored with no side effects.
REQ-016 SHALL drive ready = !rst && queue not full, computed from the registered count only, so a pop in the same cycle does not raise ready.
REQ-017 SHALL run an FSM with states IDLE, PIXEL, HLINE and FILL.
REQ-018 In IDLE, or on the final step of any command, SHALL pop the queue head when it is non-empty and load x, y, colour and a step counter.
REQ-019 SHALL make back-to-back commands issue one pixel per clock with no IDLE bubble.
REQ-020 SHALL pop a reserved opcode, set err, and return to IDLE with no plot.
REQ-021 SHALL register vga_plot, vga_x, vga_y and vga_colour; the first plot of a command accepted at edge N appears in the cycle after edge N+2 when the queue and engine are idle.
REQ-022 For PIXEL, SHALL run 1 step.
REQ-023 For HLINE, SHALL run steps x..x+len and terminate early after x = SCREEN_W-1, with no wrap to the next row.
REQ-024 For FILL, SHALL step x from 0 to SCREEN_W-1 inner and y from 0 to SCREEN_H-1 outer, for SCREEN_W*SCREEN_H cycles.
REQ-025 SHALL clip pixels: a step with x >= SCREEN_W or y >= SCREEN_H consumes one cycle with vga_plot=0, and vga_x/vga_y still show the step coordinates.
REQ-026 SHALL hold vga_plot=0 in IDLE, with vga_x, vga_y and vga_colour holding their last values.
REQ-027 SHALL drive busy = (state != IDLE) || queue non-empty.
REQ-028 SHALL perform counter and x arithmetic at 9 bits internally so that x+len cannot overflow (max 255+63).

Reset
REQ-029 On rst high at an edge, SHALL set the FSM to IDLE, empty the queue, and clear vga_plot, vga_x, vga_y, vga_colour, busy and err to 0.
REQ-030 SHALL give reset mid-command priority: it aborts the command with no further plots, and a start coincident with rst is dropped.
REQ-031 SHALL assert ready in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the opcode enum, FSM state enum, command field bit positions and default screen dimensions in package vga_pkg.
REQ-033 SHALL implement the queue as sub-module vga_cmd_fifo (synchronous, count-based full/empty, first-word registered output).
REQ-034 SHALL add no other sub-modules.

Verification
REQ-035 PIXEL test: single command y=5, x=10, colour=3 -> exactly one vga_plot pulse, 2 edges after acceptance, with (10,5,3).
REQ-036 HLINE clip test: x=157, y=0, len=9 -> plots at x=157,158,159 only, then busy falls.
REQ-037 Clipping test: PIXEL x=200, y=119 -> no vga_plot pulse, err stays 0; then PIXEL x=159, y=120 -> no pulse.
REQ-038 Back-pressure test: 6 PIXEL commands with start held high, engine busy on FILL -> ready low after 4 accepts, remaining 2 accepted later, all 6 plotted in order at 1/clk.
REQ-039 FILL test: colour=7 -> 19200 consecutive plots, last at (159,119), then IDLE.
REQ-040 Reset and error test: rst asserted mid-HLINE -> next cycle vga_plot=0 and queue empty; opcode 11 -> err=1, cleared only by rst.
